// File: rtl/df_mon_pkg.sv
// Shared types for the dataflow stall watchdog: FSM states, report kind codes
// and the width of the reported process index.
package df_mon_pkg;

    localparam int PROC_IDX_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SUSPECT,
        DEADLOCK,
        REPORTED
    } state_e;

    typedef enum logic [1:0] {
        KIND_CHAN = 2'd0,
        KIND_AXIS = 2'd1,
        KIND_BOTH = 2'd2
    } kind_e;

endpackage

// File: rtl/df_first_blocked.sv
// Lowest-index priority encoder over the blocked processes. It also reports
// which kind of block (channel, axis or both) holds that process.
module df_first_blocked
    import df_mon_pkg::*;
#(
    parameter int NUM_PROC = 9
) (
    input  logic [NUM_PROC-1:0]   chan,
    input  logic [NUM_PROC-1:0]   axis,
    output logic [PROC_IDX_W-1:0] idx,
    output logic [1:0]            kind
);

    always_comb begin
        idx  = '0;
        kind = KIND_CHAN;
        // Scan from the top down so the lowest blocked index is the last write.
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (chan[i] || axis[i]) begin
                idx = PROC_IDX_W'(i);
                if (chan[i] && axis[i])
                    kind = KIND_BOTH;
                else if (axis[i])
                    kind = KIND_AXIS;
                else
                    kind = KIND_CHAN;
            end
        end
    end

endmodule

// File: rtl/df_stall_watchdog.sv
// Debounced deadlock watchdog for an HLS dataflow region: qualifies a global
// stall over STALL_THRESH cycles, latches the verdict and issues one report.
module df_stall_watchdog
    import df_mon_pkg::*;
#(
    parameter int NUM_PROC     = 9,
    parameter int STALL_THRESH = 16,
    parameter int CNT_W        = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [NUM_PROC-1:0]   proc_idle,
    input  logic [NUM_PROC-1:0]   proc_chan_block,
    input  logic [NUM_PROC-1:0]   proc_axis_block,
    output logic                  deadlock,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  report_valid,
    input  logic                  report_ready,
    output logic [PROC_IDX_W-1:0] report_proc,
    output logic [1:0]            report_kind,
    output logic [NUM_PROC-1:0]   report_block_vec
);

    state_e                state, state_n;
    logic [CNT_W-1:0]      cnt_n;
    logic                  dl_n, rv_n;
    logic [PROC_IDX_W-1:0] rp_n;
    logic [1:0]            rk_n;
    logic [NUM_PROC-1:0]   rb_n;

    logic [NUM_PROC-1:0]   blk_vec;
    logic                  any_blk, all_stop;
    logic [PROC_IDX_W-1:0] first_idx;
    logic [1:0]            first_kind;

    assign blk_vec  = proc_chan_block | proc_axis_block;
    assign any_blk  = |blk_vec;
    // Everyone idle with nothing blocked is a finished region, not a deadlock.
    assign all_stop = (&(proc_idle | blk_vec)) && any_blk;

    df_first_blocked #(.NUM_PROC(NUM_PROC)) u_first (
        .chan (proc_chan_block),
        .axis (proc_axis_block),
        .idx  (first_idx),
        .kind (first_kind)
    );

    always_comb begin
        state_n = state;
        cnt_n   = stall_cnt;
        dl_n    = deadlock;
        rv_n    = report_valid;
        rp_n    = report_proc;
        rk_n    = report_kind;
        rb_n    = report_block_vec;
        if ((clear && state != IDLE) || !enable) begin
            state_n = (clear && state != IDLE && enable) ? RUN : IDLE;
            cnt_n   = '0;
            dl_n    = 1'b0;
            rv_n    = 1'b0;
            rp_n    = '0;
            rk_n    = '0;
            rb_n    = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
                RUN: begin
                    if (all_stop) begin
                        state_n = SUSPECT;
                        cnt_n   = CNT_W'(1);
                    end
                end
                SUSPECT: begin
                    if (!all_stop) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else if (stall_cnt == CNT_W'(STALL_THRESH - 1)) begin
                        state_n = DEADLOCK;
                        dl_n    = 1'b1;
                        rv_n    = 1'b1;
                        rp_n    = first_idx;
                        rk_n    = first_kind;
                        rb_n    = blk_vec;
                    end else if (stall_cnt != {CNT_W{1'b1}}) begin
                        cnt_n   = stall_cnt + CNT_W'(1);
                    end
                end
                DEADLOCK: begin
                    if (report_ready) begin
                        state_n = REPORTED;
                        rv_n    = 1'b0;
                    end
                end
                REPORTED: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            stall_cnt        <= '0;
            deadlock         <= 1'b0;
            report_valid     <= 1'b0;
            report_proc      <= '0;
            report_kind      <= '0;
            report_block_vec <= '0;
        end else begin
            state            <= state_n;
            stall_cnt        <= cnt_n;
            deadlock         <= dl_n;
            report_valid     <= rv_n;
            report_proc      <= rp_n;
            report_kind      <= rk_n;
            report_block_vec <= rb_n;
        end
    end

endmodule

// File: tb/tb_df_stall_watchdog.sv
// Scoreboard bench for df_stall_watchdog: directed scenarios plus random
// traffic, checked every cycle against a run-length reference model.
module tb_df_stall_watchdog;

    localparam int N  = 9;
    localparam int TH = 16;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset, enable, clear, report_ready;
    logic [N-1:0]  proc_idle, proc_chan_block, proc_axis_block;
    logic          deadlock, report_valid;
    logic [CW-1:0] stall_cnt;
    logic [4:0]    report_proc;
    logic [1:0]    report_kind;
    logic [N-1:0]  report_block_vec;

    always #5 clock = ~clock;

    df_stall_watchdog #(.NUM_PROC(N), .STALL_THRESH(TH), .CNT_W(CW)) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .clear            (clear),
        .proc_idle        (proc_idle),
        .proc_chan_block  (proc_chan_block),
        .proc_axis_block  (proc_axis_block),
        .deadlock         (deadlock),
        .stall_cnt        (stall_cnt),
        .report_valid     (report_valid),
        .report_ready     (report_ready),
        .report_proc      (report_proc),
        .report_kind      (report_kind),
        .report_block_vec (report_block_vec)
    );

    typedef struct {
        logic          dl;
        logic [CW-1:0] cnt;
        logic          rv;
        logic [4:0]    rp;
        logic [1:0]    rk;
        logic [N-1:0]  rb;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: armed = watchdog not parked, run = consecutive
    // all-stop samples since arming, verdict/pending = deadlock and report.
    bit           armed, verdict, pending;
    int           run;
    int           m_rp, m_rk;
    logic [N-1:0] m_rb;

    task automatic drop_all();
        run = 0; verdict = 0; pending = 0;
        m_rp = 0; m_rk = 0; m_rb = '0;
    endtask

    task automatic model_step(output exp_t e);
        logic [N-1:0] blk;
        bit           stop_all;
        int           first;
        blk      = proc_chan_block | proc_axis_block;
        stop_all = ((proc_idle | blk) == {N{1'b1}}) && (blk != 0);
        if (reset) begin
            drop_all(); armed = 0;
        end else if (clear && armed) begin
            drop_all(); armed = enable;
        end else if (!enable) begin
            drop_all(); armed = 0;
        end else if (!armed) begin
            armed = 1; run = 0;
        end else if (verdict) begin
            if (pending && report_ready) pending = 0;
        end else if (stop_all) begin
            run++;
            if (run == TH) begin
                verdict = 1; pending = 1;
                first = -1;
                for (int i = 0; i < N; i++)
                    if (blk[i] && first < 0) first = i;
                m_rp = first;
                m_rk = (proc_chan_block[first] && proc_axis_block[first]) ? 2 :
                       proc_axis_block[first] ? 1 : 0;
                m_rb = blk;
            end
        end else begin
            run = 0;
        end
        e.dl  = verdict;
        e.cnt = verdict ? CW'(TH - 1) : (run > 255 ? 8'hFF : CW'(run));
        e.rv  = pending;
        e.rp  = 5'(m_rp);
        e.rk  = 2'(m_rk);
        e.rb  = m_rb;
    endtask

    task automatic cyc(input bit r, input bit en, input bit cl, input bit rd,
                       input logic [N-1:0] id, input logic [N-1:0] ch,
                       input logic [N-1:0] ax);
        exp_t e;
        reset = r; enable = en; clear = cl; report_ready = rd;
        proc_idle = id; proc_chan_block = ch; proc_axis_block = ax;
        @(posedge clock);
        model_step(e);
        q.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("deadlock", 32'(deadlock), 32'(e.dl));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
            chk("report_valid", 32'(report_valid), 32'(e.rv));
            chk("report_proc", 32'(report_proc), 32'(e.rp));
            chk("report_kind", 32'(report_kind), 32'(e.rk));
            chk("report_block_vec", 32'(report_block_vec), 32'(e.rb));
        end
    end

    localparam logic [N-1:0] ALL = {N{1'b1}};
    localparam logic [N-1:0] B3  = 9'h008;
    localparam logic [N-1:0] B08 = 9'h101;

    initial begin
        logic [N-1:0] id, ch, ax;
        armed = 0; drop_all();
        reset = 1; enable = 0; clear = 0; report_ready = 0;
        proc_idle = '0; proc_chan_block = '0; proc_axis_block = '0;

        repeat (3) cyc(1, 0, 0, 0, '0, '0, '0);
        repeat (2) cyc(0, 0, 0, 0, ALL, B3, '0);

        // Busy traffic with no blocks never counts.
        repeat (100) begin
            id = N'($urandom);
            cyc(0, 1, 0, 1, id, '0, '0);
        end

        // Proc 3 channel-blocked, held past the threshold, then acknowledged.
        repeat (20) cyc(0, 1, 0, 0, ~B3, B3, '0);
        cyc(0, 1, 0, 1, ~B3, B3, '0);
        repeat (3) cyc(0, 1, 0, 0, ALL, '0, '0);

        // Clear, then a stall broken by one busy cycle at cycle 10.
        cyc(0, 1, 1, 0, ALL, '0, '0);
        repeat (9) cyc(0, 1, 0, 0, ~B3, B3, '0);
        cyc(0, 1, 0, 0, '0, '0, '0);
        repeat (20) cyc(0, 1, 0, 0, ~B3, B3, '0);

        // Clear while ready is high in DEADLOCK: clear wins.
        cyc(0, 1, 1, 1, ALL, '0, '0);

        // Procs 0 and 8 on axis, proc 0 also on channel; ready held low.
        repeat (16) cyc(0, 1, 0, 0, ~B08, 9'h001, B08);
        repeat (5)  cyc(0, 1, 0, 0, '0, '0, '0);
        cyc(0, 1, 0, 1, '0, '0, '0);
        repeat (3)  cyc(0, 1, 0, 1, ~B08, 9'h001, B08);

        // Clear from REPORTED while the stall persists: re-trigger.
        cyc(0, 1, 1, 0, ~B3, B3, '0);
        repeat (20) cyc(0, 1, 0, 0, ~B3, B3, '0);
        cyc(0, 1, 1, 0, ALL, '0, '0);

        // Normal completion: everyone idle, nothing blocked.
        repeat (200) cyc(0, 1, 0, 0, ALL, '0, '0);

        // Reset in the middle of a suspected stall.
        repeat (7) cyc(0, 1, 0, 0, ~B3, B3, '0);
        cyc(1, 1, 0, 0, ~B3, B3, '0);
        repeat (4) cyc(0, 1, 0, 0, ~B3, B3, '0);

        // Random traffic biased toward sustained stalls.
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) begin
                id = N'($urandom); ch = N'($urandom) & N'($urandom); ax = '0;
            end else begin
                ch = N'($urandom) & N'($urandom) & N'($urandom);
                ax = N'($urandom) & N'($urandom) & N'($urandom);
                id = ~(ch | ax) | N'($urandom);
            end
            cyc($urandom_range(0, 255) == 0, $urandom_range(0, 63) != 0,
                $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                id, ch, ax);
        end

        repeat (3) @(posedge clock);
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/df_stall_watchdog.md
# df_stall_watchdog

Sequencing watchdog for an HLS dataflow region in the decode pipeline. Samples per-process idle, channel-block and AXI-stream-block status every cycle, qualifies a global stall only after it persists for a programmable number of consecutive cycles, then latches a deadlock verdict. It issues one valid/ready diagnostic report naming the first blocked process and the blocking kind, and holds the verdict until software or the testbench clears it. It replaces single-cycle stop detection with a debounced, reportable controller.

## Interface
- NUM_PROC, 9, number of dataflow processes monitored (1..32)
- STALL_THRESH, 16, consecutive all-stop cycles required to declare deadlock (2..2^CNT_W-1)
- CNT_W, 8, stall counter width
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- enable  in  1  watchdog armed when 1; when 0, FSM held in IDLE
- clear  in  1  single-cycle pulse; drops latched verdict, returns to RUN/IDLE
- proc_idle  in  NUM_PROC  process i idle
- proc_chan_block  in  NUM_PROC  process i blocked on internal FIFO/PIPO channel
- proc_axis_block  in  NUM_PROC  process i blocked on external AXI-stream port
- deadlock  out  1  latched verdict
- stall_cnt  out  CNT_W  current consecutive all-stop count, saturating
- report_valid  out  1  diagnostic report pending
- report_ready  in  1  consumer accepts report
- report_proc  out  5  lowest index of a blocked process at detection
- report_kind  out  2  0 = channel, 1 = axis, 2 = both on report_proc
- report_block_vec  out  NUM_PROC  snapshot of (chan | axis) at detection

## Operation
- stop_i = idle_i | chan_i | axis_i; any_blk = |(chan | axis); all_stop = &stop & any_blk. All-idle with no block is normal completion, never deadlock.
- FSM states: IDLE, RUN, SUSPECT, DEADLOCK, REPORTED.
- IDLE: enable=1 -> RUN. stall_cnt held 0.
- RUN: all_stop -> SUSPECT, stall_cnt <= 1.
- SUSPECT: !all_stop -> RUN, stall_cnt <= 0. all_stop and stall_cnt == STALL_THRESH-1 -> DEADLOCK; otherwise stall_cnt++.
- On entry to DEADLOCK, capture report_proc, report_kind and report_block_vec from the inputs of the transition cycle. Assert deadlock=1 and report_valid=1.
- DEADLOCK: report_valid && report_ready -> REPORTED, report_valid <= 0. Inputs are ignored and the snapshot is frozen.
- REPORTED: deadlock stays 1 and the snapshot stays readable until clear.
- clear (any state except IDLE) -> RUN if enable, else IDLE. All outputs return to their reset values.
- enable=0 in any state -> IDLE next edge. Verdict and report are dropped.
- Priority: reset > clear > !enable > FSM transition.
- stall_cnt saturates at 2^CNT_W-1. It never wraps, although with a legal STALL_THRESH it never exceeds STALL_THRESH-1 before DEADLOCK. It holds its final value while in DEADLOCK/REPORTED.

## Timing
- Reset values: deadlock=0, stall_cnt=0, report_valid=0, report_proc=0, report_kind=0, report_block_vec=0, FSM=IDLE.
- If all_stop is first seen at edge k and held, deadlock and report_valid rise after edge k+STALL_THRESH-1. That is STALL_THRESH registered samples.
- A single non-stop cycle before the threshold resets the count. The next stop starts again at 1.
- report_valid is stable until the handshake completes. The handshake completes on the same edge where valid and ready are both 1.
- If clear and report_ready are both 1 in DEADLOCK, clear wins and no report is counted.
- If reset is asserted mid-SUSPECT, all state reaches reset values on the next edge.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package df_mon_pkg holds the FSM state enum (IDLE, RUN, SUSPECT, DEADLOCK, REPORTED), the report_kind encodings (KIND_CHAN=0, KIND_AXIS=1, KIND_BOTH=2) and the localparam PROC_IDX_W=5.
- One sub-module, df_first_blocked: a combinational lowest-index priority encoder over (chan | axis). It returns the index and per-index kind.

## Test plan
- Reset, then enable=1 with a mixed idle/busy pattern and no blocks for 100 cycles -> deadlock stays 0 and stall_cnt stays 0.
- STALL_THRESH=16; proc 3 chan-blocked, all others idle, held 16 cycles -> deadlock=1 on the 16th edge; report_proc=3, report_kind=0, report_block_vec=0x008.
- Same stall with one busy cycle inserted at cycle 10, then held -> deadlock rises 16 cycles after the busy cycle, not before.
- Procs 0 and 8 blocked on axis, proc 0 also chan-blocked -> report_proc=0, report_kind=2, report_block_vec=0x101. report_ready low for 5 cycles keeps report_valid=1 with the snapshot unchanged; ready high -> valid falls, deadlock stays 1.
- In REPORTED, pulse clear with enable=1 -> next cycle deadlock=0, report fields=0, FSM=RUN. A persistent stall re-triggers after 16 cycles.
- All processes idle with no block for 200 cycles -> never deadlock. Reset asserted mid-SUSPECT (stall_cnt=7) -> stall_cnt=0 and FSM=IDLE next edge.
